// File: rtl/bit_range_inserter_if.sv
// Request/response bundle for the serial bit-range inserter.
interface bit_range_inserter_if;
  logic        Start;
  logic [7:0]  StartBit;
  logic [7:0]  EndBit;
  logic [31:0] FieldIn;
  logic [31:0] BaseWord;
  logic        Busy;
  logic [31:0] Result;
  logic        Valid_Output;
  logic        Error;

  // Requester side: drives the job, observes the packed word.
  modport master (
    output Start, StartBit, EndBit, FieldIn, BaseWord,
    input  Busy, Result, Valid_Output, Error
  );

  // Inserter side.
  modport slave (
    input  Start, StartBit, EndBit, FieldIn, BaseWord,
    output Busy, Result, Valid_Output, Error
  );
endinterface

// File: rtl/bit_range_inserter.sv
// Serial bit-field packer: writes FieldIn[W-1:0] into BaseWord bits
// [StartBit-1 .. EndBit-1], one bit per clock, then pulses Valid_Output.
module bit_range_inserter (
  input  logic                  Main_CLK,
  input  logic                  Main_RST_n,
  bit_range_inserter_if.slave   bus
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BIT_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BIT_W-1:0]    end_q, end_d;
  logic [BIT_W-1:0]    pos_q, pos_d;
  logic [BIT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   field_q, field_d;
  logic [WORD_W-1:0]   base_q, base_d;
  logic [WORD_W-1:0]   work_q, work_d;
  logic                flag_q, flag_d;
  logic [WORD_W-1:0]   result_q, result_d;
  logic                valid_q, valid_d;
  logic                error_q, error_d;
  logic                busy_q, busy_d;
  logic                range_ok_c;

  // Range is usable only if 1 <= StartBit <= EndBit <= 32.
  assign range_ok_c = (bus.StartBit != BIT_W'(0)) &&
                      (bus.StartBit <= bus.EndBit) &&
                      (bus.EndBit <= BIT_W'(WORD_W));

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge Main_CLK) begin
    if (!Main_RST_n) begin
      state_q  <= S_IDLE;
      end_q    <= '0;
      pos_q    <= '0;
      cnt_q    <= '0;
      field_q  <= '0;
      base_q   <= '0;
      work_q   <= '0;
      flag_q   <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      end_q    <= end_d;
      pos_q    <= pos_d;
      cnt_q    <= cnt_d;
      field_q  <= field_d;
      base_q   <= base_d;
      work_q   <= work_d;
      flag_q   <= flag_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and datapath: latch in IDLE, one bit per cycle in SHIFT, publish in DONE.
  always_comb begin
    state_d  = state_q;
    end_d    = end_q;
    pos_d    = pos_q;
    cnt_d    = cnt_q;
    field_d  = field_q;
    base_d   = base_q;
    work_d   = work_q;
    flag_d   = flag_q;
    result_d = result_q;
    error_d  = error_q;
    valid_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          field_d = bus.FieldIn;
          base_d  = bus.BaseWord;
          work_d  = bus.BaseWord;
          end_d   = bus.EndBit;
          pos_d   = bus.StartBit - BIT_W'(1);
          cnt_d   = '0;
          flag_d  = !range_ok_c;
          state_d = range_ok_c ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        work_d[pos_q[4:0]] = field_q[cnt_q[4:0]];
        pos_d = pos_q + BIT_W'(1);
        cnt_d = cnt_q + BIT_W'(1);
        if (pos_q == end_q - BIT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        result_d = flag_q ? base_q : work_q;
        error_d  = flag_q;
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Busy tracks the registered state so it rises on the Start edge.
  always_comb begin
    busy_d = (state_d != S_IDLE);
  end

  assign bus.Busy         = busy_q;
  assign bus.Result       = result_q;
  assign bus.Valid_Output = valid_q;
  assign bus.Error        = error_q;

endmodule

// File: tb/tb_bit_range_inserter.sv
// Self-checking bench for bit_range_inserter: job-level reference model
// compared every cycle, plus directed literal expectations.
module tb_bit_range_inserter;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  bit_range_inserter_if bus();

  bit_range_inserter dut (
    .Main_CLK   (clk),
    .Main_RST_n (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result for one request, straight from the field-placement rule.
  function automatic logic [31:0] ref_word(input int sb, input int eb,
                                           input logic [31:0] field,
                                           input logic [31:0] base);
    logic [31:0] r;
    r = base;
    if (sb >= 1 && sb <= eb && eb <= 32) begin
      for (int i = 0; i < 32; i++) begin
        if (i >= sb - 1 && i <= eb - 1) r[i] = field[i - (sb - 1)];
      end
    end
    return r;
  endfunction

  function automatic bit range_ok(input int sb, input int eb);
    return (sb >= 1 && sb <= eb && eb <= 32);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Job-level model: one outstanding job completes a fixed latency after acceptance.
  logic [31:0] m_result;
  logic        m_error, m_valid, m_busy;
  bit          have_job;
  int          job_due;
  logic [31:0] job_res;
  logic        job_err;

  always @(posedge clk) begin
    int sb, eb;
    cyc++;
    if (!rst_n) begin
      have_job = 0;
      m_result = '0;
      m_error  = 1'b0;
      m_valid  = 1'b0;
      m_busy   = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (have_job && cyc == job_due) begin
        m_result = job_res;
        m_error  = job_err;
        m_valid  = 1'b1;
        have_job = 0;
      end else if (!have_job && bus.Start === 1'b1) begin
        sb = int'(bus.StartBit);
        eb = int'(bus.EndBit);
        job_res  = ref_word(sb, eb, bus.FieldIn, bus.BaseWord);
        job_err  = !range_ok(sb, eb);
        job_due  = cyc + (range_ok(sb, eb) ? (eb - sb + 2) : 1);
        have_job = 1;
      end
      m_busy = have_job;
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("valid", 32'(bus.Valid_Output), 32'(m_valid));
      chk("busy",  32'(bus.Busy),         32'(m_busy));
      chk("result", bus.Result,           m_result);
      chk("error", 32'(bus.Error),        32'(m_error));
    end
  end

  // Issue one request at a falling edge and wait for its Valid pulse.
  task automatic do_job(input int sb, input int eb, input logic [31:0] field,
                        input logic [31:0] base, output int lat, output int busy_cnt);
    int n;
    bus.StartBit = 8'(sb);
    bus.EndBit   = 8'(eb);
    bus.FieldIn  = field;
    bus.BaseWord = base;
    bus.Start    = 1'b1;
    n = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      bus.Start = 1'b0;
      n++;
      if (bus.Busy === 1'b1) busy_cnt++;
    end while (bus.Valid_Output !== 1'b1 && n < 50);
    if (n >= 50) chk("timeout", 32'(n), 32'(0));
    lat = n - 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int lat, bc, sb, eb, w;
    logic [31:0] f, b, r, mask;

    rst_n = 1'b0;
    bus.Start = 1'b0; bus.StartBit = '0; bus.EndBit = '0;
    bus.FieldIn = '0; bus.BaseWord = '0;
    idle(3);
    chk("rst_result", bus.Result, 32'h0);
    chk("rst_valid",  32'(bus.Valid_Output), 32'h0);
    chk("rst_busy",   32'(bus.Busy), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Small field
    chk("model_small", ref_word(2, 4, 32'h3, 32'h0), 32'h00000006);
    do_job(2, 4, 32'h3, 32'h0, lat, bc);
    chk("small_lat", 32'(lat), 32'd4);
    chk("small_busy", 32'(bc), 32'd4);
    chk("small_res", bus.Result, 32'h00000006);
    chk("small_err", 32'(bus.Error), 32'h0);
    idle(2);

    // Full word
    do_job(1, 32, 32'hDEADBEEF, 32'h12345678, lat, bc);
    chk("full_lat", 32'(lat), 32'd33);
    chk("full_res", bus.Result, 32'hDEADBEEF);
    idle(1);

    // Exponent clear, upper field bits ignored
    chk("model_exp", ref_word(24, 31, 32'hFFFFFF00, 32'hFFFFFFFF), 32'h807FFFFF);
    do_job(24, 31, 32'hFFFFFF00, 32'hFFFFFFFF, lat, bc);
    chk("exp_lat", 32'(lat), 32'd9);
    chk("exp_res", bus.Result, 32'h807FFFFF);
    idle(2);

    // Invalid ranges, then a valid one clears Error
    do_job(5, 3, 32'hFFFF, 32'hA5A5A5A5, lat, bc);
    chk("inv1_lat", 32'(lat), 32'd1);
    chk("inv1_err", 32'(bus.Error), 32'h1);
    chk("inv1_res", bus.Result, 32'hA5A5A5A5);
    idle(1);
    do_job(0, 4, 32'hFFFF, 32'hA5A5A5A5, lat, bc);
    chk("inv2_lat", 32'(lat), 32'd1);
    chk("inv2_err", 32'(bus.Error), 32'h1);
    chk("inv2_res", bus.Result, 32'hA5A5A5A5);
    idle(1);
    do_job(1, 33, 32'hFFFF, 32'hA5A5A5A5, lat, bc);
    chk("inv3_lat", 32'(lat), 32'd1);
    chk("inv3_err", 32'(bus.Error), 32'h1);
    chk("inv3_res", bus.Result, 32'hA5A5A5A5);
    chk("inv3_busy", 32'(bc), 32'd1);
    idle(1);
    do_job(1, 4, 32'h5, 32'h0, lat, bc);
    chk("clr_err", 32'(bus.Error), 32'h0);
    chk("clr_res", bus.Result, 32'h00000005);
    idle(2);

    // Second Start during SHIFT is ignored
    bus.StartBit = 8'd9; bus.EndBit = 8'd16;
    bus.FieldIn = 32'hAB; bus.BaseWord = 32'h0;
    bus.Start = 1'b1;
    idle(1);
    bus.Start = 1'b0;
    idle(2);
    bus.StartBit = 8'd1; bus.EndBit = 8'd4;
    bus.FieldIn = 32'hF; bus.BaseWord = 32'hFFFF0000;
    bus.Start = 1'b1;
    idle(1);
    bus.Start = 1'b0;
    lat = 0;
    while (bus.Valid_Output !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("ign_res", bus.Result, 32'h0000AB00);
    idle(2);

    // Reset at edge 2 of a W=8 job
    bus.StartBit = 8'd1; bus.EndBit = 8'd8;
    bus.FieldIn = 32'hFF; bus.BaseWord = 32'h0;
    bus.Start = 1'b1;
    idle(1);
    bus.Start = 1'b0;
    idle(1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk("rstmid_busy", 32'(bus.Busy), 32'h0);
    chk("rstmid_res",  bus.Result, 32'h0);
    chk("rstmid_valid", 32'(bus.Valid_Output), 32'h0);
    idle(12);
    chk("rstmid_res2", bus.Result, 32'h0);

    // Back-to-back: second Start in the Valid cycle
    do_job(1, 3, 32'h7, 32'h0, lat, bc);
    chk("b2b1_res", bus.Result, 32'h00000007);
    do_job(5, 12, 32'h3C, 32'h80000001, lat, bc);
    chk("b2b2_lat", 32'(lat), 32'd9);
    chk("b2b2_res", bus.Result, 32'h800003C1);
    idle(2);

    // Random sweep with round-trip extraction
    for (int k = 0; k < 20; k++) begin
      sb = $urandom_range(1, 32);
      eb = $urandom_range(sb, 32);
      f  = $urandom;
      b  = $urandom;
      do_job(sb, eb, f, b, lat, bc);
      w = eb - sb + 1;
      mask = (w == 32) ? 32'hFFFFFFFF : ((32'h1 << w) - 32'h1);
      r = bus.Result;
      chk("rt_lat", 32'(lat), 32'(w + 1));
      chk("rt_field", (r >> (sb - 1)) & mask, f & mask);
      chk("rt_base", r & ~(mask << (sb - 1)), b & ~(mask << (sb - 1)));
      if (k % 3 == 0) idle(1);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
